// File: rtl/round_robin_dispatch_if.sv
// ---------------------------------------------------------------------------
// round_robin_dispatch_if
//
// Bundles the input stream and the per-port output bus of the
// round-robin dispatcher. There is one interface for both sides.
//
//   i_valid / o_ready / i_data      producer-side valid/ready stream
//   i_port_en     [PORTS_N]         per-port enable; disabled ports are skipped
//   o_port_valid  [PORTS_N]         one-hot (or zero) valid to each consumer
//   i_port_ready  [PORTS_N]         per-consumer ready
//   o_port_data   [DATA_W]          payload, shared by every consumer
//   o_port_sel    [PORTS_W]         binary index of the port being driven
//
// Modports:
//   slave  - the dispatcher itself
//   master - the environment: the producer plus the bank of consumers
// ---------------------------------------------------------------------------
interface round_robin_dispatch_if #(
    parameter int PORTS_N = 3,
    parameter int DATA_W  = 32
);
    localparam int PORTS_W = $clog2(PORTS_N);

    logic                i_valid;
    logic                o_ready;
    logic [DATA_W-1:0]   i_data;
    logic [PORTS_N-1:0]  i_port_en;
    logic [PORTS_N-1:0]  o_port_valid;
    logic [PORTS_N-1:0]  i_port_ready;
    logic [DATA_W-1:0]   o_port_data;
    logic [PORTS_W-1:0]  o_port_sel;

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_port_en,
        input  i_port_ready,
        output o_ready,
        output o_port_valid,
        output o_port_data,
        output o_port_sel
    );

    modport master (
        output i_valid,
        output i_data,
        output i_port_en,
        output i_port_ready,
        input  o_ready,
        input  o_port_valid,
        input  o_port_data,
        input  o_port_sel
    );
endinterface

// File: rtl/round_robin_dispatch.sv
// ---------------------------------------------------------------------------
// round_robin_dispatch
//
// Takes a single valid/ready stream and distributes its beats to PORTS_N
// consumers in strict rotating order. Ports whose enable is low are skipped.
// The output is a one-entry registered stage. A new beat can replace the
// held beat in the same cycle that the held beat is taken, so the block can
// sustain one beat per cycle.
//
// Ports:
//   i_clk      clock
//   i_reset_n  asynchronous active-low reset; a held beat is discarded
//   bus        round_robin_dispatch_if.slave (stream in, port bank out)
//
// The outputs o_port_valid, o_port_data and o_port_sel come straight from
// flops. o_ready depends combinationally on i_port_ready and i_port_en only.
// ---------------------------------------------------------------------------
module round_robin_dispatch #(
    parameter int PORTS_N = 3,
    parameter int DATA_W  = 32
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    round_robin_dispatch_if.slave        bus
);
    localparam int PORTS_W = $clog2(PORTS_N);

    // Returns a mask of all port indices whose binary code has bit b set.
    // The one-hot to binary encoder below uses it.
    function automatic logic [PORTS_N-1:0] bit_mask(input int b);
        logic [PORTS_N-1:0] m;
        m = '0;
        for (int i = 0; i < PORTS_N; i++) begin
            m[i] = ((i >> b) & 1) != 0;
        end
        return m;
    endfunction

    // Held beat. valid_reg is the one-hot target while the stage is full,
    // and zero while it is empty, so "full" is simply |valid_reg.
    logic [PORTS_N-1:0] valid_reg;
    logic [DATA_W-1:0]  data_reg;
    logic [PORTS_W-1:0] sel_idx_reg;
    logic [PORTS_N-1:0] ptr_reg;       // one-hot next-candidate port

    logic [PORTS_N-1:0] ge_ptr;        // ports at or above the pointer
    logic [PORTS_N-1:0] en_hi;
    logic [PORTS_N-1:0] pick_src;
    logic [PORTS_N-1:0] pick;          // one-hot chosen port
    logic [PORTS_W-1:0] pick_idx;
    logic [PORTS_N-1:0] ptr_next;

    logic full;
    logic any_en;
    logic out_fire;
    logic in_fire;

    // -----------------------------------------------------------------------
    // Rotating priority search.
    // ge_ptr is a thermometer mask that covers the pointer and every port
    // above it. If an enabled port exists in that upper region, the lowest
    // one is chosen. Otherwise the search wraps, and the lowest enabled port
    // overall is chosen. Isolating the lowest set bit with x & -x avoids any
    // variable indexing.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < PORTS_N; gi++) begin : g_ge_ptr
        assign ge_ptr[gi] = |ptr_reg[gi:0];
    end

    assign en_hi    = bus.i_port_en & ge_ptr;
    assign pick_src = (|en_hi) ? en_hi : bus.i_port_en;
    assign pick     = pick_src & (~pick_src + PORTS_N'(1));

    // The next candidate is the port after the chosen one, with wrap.
    assign ptr_next = {pick[PORTS_N-2:0], pick[PORTS_N-1]};

    // One-hot to binary encoding of the chosen port.
    for (genvar gi = 0; gi < PORTS_W; gi++) begin : g_enc
        localparam logic [PORTS_N-1:0] MASK = bit_mask(gi);
        assign pick_idx[gi] = |(pick & MASK);
    end

    // -----------------------------------------------------------------------
    // Handshakes
    // -----------------------------------------------------------------------
    assign full     = |valid_reg;
    assign any_en   = |bus.i_port_en;
    // Only the targeted port's ready can complete a transfer.
    assign out_fire = |(valid_reg & bus.i_port_ready);
    // With every port disabled there is nowhere to send a beat, so the
    // input is stalled and the pointer is left untouched.
    assign bus.o_ready = (~full | out_fire) & any_en;
    assign in_fire  = bus.i_valid & bus.o_ready;

    // -----------------------------------------------------------------------
    // Output stage. i_port_en is consulted only when a beat is accepted.
    // Dropping the enable of a port that already holds a beat therefore
    // leaves that beat in place until the port takes it.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_reg   <= '0;
            data_reg    <= '0;
            sel_idx_reg <= '0;
            ptr_reg     <= PORTS_N'(1);
        end else begin
            if (in_fire) begin
                valid_reg   <= pick;
                data_reg    <= bus.i_data;
                sel_idx_reg <= pick_idx;
                ptr_reg     <= ptr_next;
            end else if (out_fire) begin
                // Data and select keep their last values once the stage empties.
                valid_reg <= '0;
            end
        end
    end

    assign bus.o_port_valid = valid_reg;
    assign bus.o_port_data  = data_reg;
    assign bus.o_port_sel   = sel_idx_reg;

endmodule
